// File: rtl/fifo_st_source.sv
// Avalon-ST source: pops a registered-output FIFO into a 3-entry skid buffer and presents beats with optional packet framing.
// Latency: fifo_rd_o in cycle t gives st_valid_o in cycle t+2 when the buffer is empty and the ready allowance is open.
// Backpressure: st_ready_i is honoured READY_LATENCY cycles later; refill stops once buffered plus in-flight words reach 3.
// Optional framing (st_sop_o/st_eop_o every PKT_LEN beats) is compiled in only when FIFO_ST_SOURCE_PKT_EN is defined.
module fifo_st_source #(
  parameter int DATABITS_PER_SYMBOL = 8,
  parameter int SYMBOLS_PER_BEAT    = 4,
  parameter int WIDTH               = DATABITS_PER_SYMBOL * SYMBOLS_PER_BEAT,
  parameter int READY_LATENCY       = 2,
  parameter int PKT_LEN             = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] fifo_data_i,
  input  logic             fifo_non_empty_i,
  output logic             fifo_rd_o,
  input  logic             st_ready_i,
  output logic             st_valid_o,
  output logic [WIDTH-1:0] st_data_o,
  output logic             st_sop_o,
  output logic             st_eop_o
);

  localparam int DEPTH = 3;

  generate
    if (READY_LATENCY < 0 || READY_LATENCY > 4 || PKT_LEN < 1 || PKT_LEN > 65535) begin : g_bad_cfg
      $error("fifo_st_source: READY_LATENCY must be 0..4 and PKT_LEN 1..65535");
    end
  endgenerate

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  logic [1:0]       cnt;
  logic             inflight;
  logic [2:0]       occ;
  logic             allow;
  logic             xfer;

  // Circular pointer step over the three skid slots.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Words already buffered plus the one still arriving from the FIFO; keeping
  // this below 3 before issuing a read is what makes overflow impossible.
  assign occ = {1'b0, cnt} + {2'b0, inflight};

  // Read issue depends only on local state, never on st_ready_i. Held low
  // during reset so no FIFO word is popped and then thrown away.
  assign fifo_rd_o = !rst_i && fifo_non_empty_i && (occ < 3'd3);

  // Ready allowance: st_ready_i itself at latency 0, else its delayed copy.
  generate
    if (READY_LATENCY == 0) begin : g_rl0
      assign allow = st_ready_i;
    end else begin : g_rl
      logic [READY_LATENCY:1] rdy_d;

      // Shift st_ready_i so rdy_d[k] is the ready seen k cycles ago.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          rdy_d <= '0;
        end else begin
          rdy_d[1] <= st_ready_i;
          for (int k = 2; k <= READY_LATENCY; k++) begin
            rdy_d[k] <= rdy_d[k-1];
          end
        end
      end

      assign allow = rdy_d[READY_LATENCY];
    end
  endgenerate

  // At latency 0 the allowance is st_ready_i, so valid already implies ready;
  // at latency > 0 the sink must take every valid beat. Either way a valid
  // beat is a transfer.
  assign st_valid_o = !rst_i && (cnt != 2'd0) && allow;
  assign xfer       = st_valid_o;
  assign st_data_o  = mem[rd_ptr];

  // Skid buffer: capture the word read last cycle, retire on transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt      <= 2'd0;
      inflight <= 1'b0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      inflight <= fifo_rd_o;
      if (inflight) begin
        mem[wr_ptr] <= fifo_data_i;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (xfer) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({inflight, xfer})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef FIFO_ST_SOURCE_PKT_EN
  localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

  logic [15:0] bcnt;

  // Beat position within the current packet; reset restarts framing at sop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bcnt <= 16'd0;
    end else if (xfer) begin
      bcnt <= (bcnt == LAST_BEAT) ? 16'd0 : bcnt + 16'd1;
    end
  end

  assign st_sop_o = st_valid_o && (bcnt == 16'd0);
  assign st_eop_o = st_valid_o && (bcnt == LAST_BEAT);
`else
  assign st_sop_o = 1'b0;
  assign st_eop_o = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_st_source.sv
// Bench for fifo_st_source: one instance at ready latency 2, one at ready latency 0,
// each fed by a small registered-output FIFO model; expected sop/eop follow FIFO_ST_SOURCE_PKT_EN.
module tb_fifo_st_source;

`ifdef FIFO_ST_SOURCE_PKT_EN
  localparam bit PKT_EN = 1'b1;
`else
  localparam bit PKT_EN = 1'b0;
`endif

  typedef struct {
    logic        rdy;
    logic        rd;
    logic        vld;
    logic [31:0] dat;
    logic        sop;
    logic        eop;
  } vec_t;

  typedef struct {
    logic [31:0] dat;
    logic        sop;
    logic        eop;
    int          cyc;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Instance A: READY_LATENCY=2, PKT_LEN=4
  logic        a_rst, a_ne, a_rd, a_rdy, a_vld, a_sop, a_eop;
  logic [31:0] a_dq, a_dat;
  logic [31:0] a_mem [0:15];
  int          a_head, a_tail;

  // Instance B: READY_LATENCY=0, PKT_LEN=4
  logic        b_rst, b_ne, b_rd, b_rdy, b_vld, b_sop, b_eop;
  logic [31:0] b_dq, b_dat;
  logic [31:0] b_mem [0:15];
  int          b_head, b_tail;

  assign a_ne = (a_head != a_tail);
  assign b_ne = (b_head != b_tail);

  always @(posedge clk) begin
    if (a_rst) begin
      a_head <= 0;
      a_dq   <= '0;
    end else if (a_rd) begin
      a_dq   <= a_mem[a_head];
      a_head <= a_head + 1;
    end
  end

  always @(posedge clk) begin
    if (b_rst) begin
      b_head <= 0;
      b_dq   <= '0;
    end else if (b_rd) begin
      b_dq   <= b_mem[b_head];
      b_head <= b_head + 1;
    end
  end

  fifo_st_source #(.READY_LATENCY(2), .PKT_LEN(4)) u_a (
    .clk_i(clk), .rst_i(a_rst),
    .fifo_data_i(a_dq), .fifo_non_empty_i(a_ne), .fifo_rd_o(a_rd),
    .st_ready_i(a_rdy), .st_valid_o(a_vld), .st_data_o(a_dat),
    .st_sop_o(a_sop), .st_eop_o(a_eop)
  );

  fifo_st_source #(.READY_LATENCY(0), .PKT_LEN(4)) u_b (
    .clk_i(clk), .rst_i(b_rst),
    .fifo_data_i(b_dq), .fifo_non_empty_i(b_ne), .fifo_rd_o(b_rd),
    .st_ready_i(b_rdy), .st_valid_o(b_vld), .st_data_o(b_dat),
    .st_sop_o(b_sop), .st_eop_o(b_eop)
  );

  beat_t alog[$];
  beat_t blog[$];
  beat_t cur[$];
  int    exp_cyc[$];
  int    a_ovf = 0, b_ovf = 0, a_peak = 0, b_vnr = 0;
  vec_t  tbl [0:6];

  task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sample at the falling edge: log beats and track buffer occupancy.
  task automatic sample();
    int occ;
    @(negedge clk);
    if (a_vld) alog.push_back('{a_dat, a_sop, a_eop, cyc});
    if (b_vld) blog.push_back('{b_dat, b_sop, b_eop, cyc});
    if (b_vld && !b_rdy) b_vnr++;
    occ = int'(u_a.cnt) + int'(u_a.inflight);
    if (occ > 3) a_ovf++;
    if (occ > a_peak) a_peak = occ;
    occ = int'(u_b.cnt) + int'(u_b.inflight);
    if (occ > 3) b_ovf++;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Two reset edges with the FIFO preloaded; outputs must be quiet throughout.
  task automatic reset_a(input int n, input logic [31:0] base);
    a_rst = 1'b1;
    a_rdy = 1'b1;
    for (int i = 0; i < n; i++) a_mem[i] = base + 32'(i);
    a_tail = n;
    @(posedge clk); #1;
    @(negedge clk);
    chk_b("a_rst_rd", a_rd, 1'b0);
    chk_b("a_rst_vld", a_vld, 1'b0);
    chk_w("a_rst_dat", a_dat, 32'h0);
    chk_b("a_rst_sop", a_sop, 1'b0);
    chk_b("a_rst_eop", a_eop, 1'b0);
    @(posedge clk); #1;
    a_rst = 1'b0;
    cyc   = 0;
  endtask

  task automatic reset_b(input int n, input logic [31:0] base);
    b_rst = 1'b1;
    b_rdy = 1'b1;
    for (int i = 0; i < n; i++) b_mem[i] = base + 32'(i);
    b_tail = n;
    @(posedge clk); #1;
    @(negedge clk);
    chk_b("b_rst_rd", b_rd, 1'b0);
    chk_b("b_rst_vld", b_vld, 1'b0);
    chk_w("b_rst_dat", b_dat, 32'h0);
    @(posedge clk); #1;
    b_rst = 1'b0;
    cyc   = 0;
  endtask

  // Compare the logged beats in `cur` against data base+i, cycles exp_cyc, framing every 4 beats.
  task automatic check_beats(input string tag, input int n, input logic [31:0] base);
    chk_w($sformatf("%s_count", tag), 32'(cur.size()), 32'(n));
    for (int i = 0; i < n && i < cur.size(); i++) begin
      chk_w($sformatf("%s_dat[%0d]", tag, i), cur[i].dat, base + 32'(i));
      chk_w($sformatf("%s_cyc[%0d]", tag, i), 32'(cur[i].cyc), 32'(exp_cyc[i]));
      chk_b($sformatf("%s_sop[%0d]", tag, i), cur[i].sop, PKT_EN && (i % 4 == 0));
      chk_b($sformatf("%s_eop[%0d]", tag, i), cur[i].eop, PKT_EN && (i % 4 == 3));
    end
  endtask

  initial begin
    a_rst = 1'b1; b_rst = 1'b1; a_rdy = 1'b1; b_rdy = 1'b1;
    a_tail = 0; b_tail = 0;

    // Cycle-by-cycle view after reset with words 1..4 and ready held high.
    //           rdy   rd    vld   dat    sop     eop
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0,   1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0,   1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h1, PKT_EN, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h2, 1'b0,   1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 32'h3, 1'b0,   1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 32'h4, 1'b0,   PKT_EN};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 32'h2, 1'b0,   1'b0};

    @(posedge clk); #1;

    // Reset then stream four words.
    reset_a(4, 32'h1);
    alog.delete();
    for (int c = 0; c < 7; c++) begin
      a_rdy = tbl[c].rdy;
      sample();
      chk_b($sformatf("tbl_rd[%0d]", c), a_rd, tbl[c].rd);
      chk_b($sformatf("tbl_vld[%0d]", c), a_vld, tbl[c].vld);
      chk_w($sformatf("tbl_dat[%0d]", c), a_dat, tbl[c].dat);
      chk_b($sformatf("tbl_sop[%0d]", c), a_sop, tbl[c].sop);
      chk_b($sformatf("tbl_eop[%0d]", c), a_eop, tbl[c].eop);
      advance();
    end
    cur = alog;
    exp_cyc = '{2, 3, 4, 5};
    check_beats("stream", 4, 32'h1);

    // Backpressure: ready low in cycles 5..7 closes the allowance in cycles 7..9.
    reset_a(8, 32'h100);
    alog.delete();
    a_peak = 0;
    for (int c = 0; c < 16; c++) begin
      a_rdy = !(c >= 5 && c <= 7);
      sample();
      advance();
    end
    cur = alog;
    exp_cyc = '{2, 3, 4, 5, 6, 10, 11, 12};
    check_beats("bp", 8, 32'h100);
    chk_w("bp_peak_occ", 32'(a_peak), 32'd3);

    // Framing over ten back-to-back beats.
    a_rdy = 1'b1;
    reset_a(10, 32'h400);
    alog.delete();
    for (int c = 0; c < 14; c++) begin
      sample();
      advance();
    end
    cur = alog;
    exp_cyc = '{2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
    check_beats("frame", 10, 32'h400);

    // Reset after beat 2 of a packet, then four fresh words.
    reset_a(6, 32'h500);
    alog.delete();
    for (int c = 0; c < 5; c++) begin
      sample();
      advance();
    end
    cur = alog;
    exp_cyc = '{2, 3, 4};
    check_beats("pre_rst", 3, 32'h500);
    reset_a(4, 32'h600);
    alog.delete();
    for (int c = 0; c < 8; c++) begin
      sample();
      advance();
    end
    cur = alog;
    exp_cyc = '{2, 3, 4, 5};
    check_beats("post_rst", 4, 32'h600);

    // Ready latency 0 with ready toggling 1010...; data must hold across ready-low cycles.
    a_rst = 1'b1;
    reset_b(6, 32'h700);
    blog.delete();
    for (int c = 0; c < 15; c++) begin
      b_rdy = (c % 2 == 0);
      sample();
      if (c % 2 == 1 && c >= 3 && c <= 11)
        chk_w($sformatf("rl0_hold[%0d]", c), b_dat, 32'h700 + 32'((c - 1) / 2));
      advance();
    end
    cur = blog;
    exp_cyc = '{2, 4, 6, 8, 10, 12};
    check_beats("rl0", 6, 32'h700);
    chk_w("rl0_valid_without_ready", 32'(b_vnr), 32'd0);
    chk_w("a_overflow", 32'(a_ovf), 32'd0);
    chk_w("b_overflow", 32'(b_ovf), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
